alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle instruction sequencer that acts as the master of the 32 x 16-bit register file. It accepts one register-to-register or immediate instruction at a time over a valid/ready handshake. For each instruction it drives the register file's two combinational read ports, computes a 16-bit ALU result with carry and zero flags, and issues a single write-back on the register file's synchronous write port. It sits between the instruction source (test harness or a future fetch unit) and the register file; its register-file ports connect one-to-one.

## Interface
- DATA_W, 16, datapath and register width
- ADDR_W, 5, register address width (32 registers)

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- instrValid  in  1  instruction bundle valid
- instrReady  out  1  sequencer can accept an instruction
- opcode  in  3  operation select
- dstAddr  in  ADDR_W  destination register
- srcAddrA  in  ADDR_W  operand A register
- srcAddrB  in  ADDR_W  operand B register
- imm  in  DATA_W  immediate operand
- readAddrA  out  ADDR_W  register file read port A address
- readAddrB  out  ADDR_W  register file read port B address
- readDataA  in  DATA_W  register file read data A (combinational)
- readDataB  in  DATA_W  register file read data B (combinational)
- writeEnable  out  1  register file write strobe
- writeAddr  out  ADDR_W  register file write address
- writeData  out  DATA_W  register file write data
- carryFlag  out  1  carry/borrow from last arithmetic instruction
- zeroFlag  out  1  last result == 0
- done  out  1  one-cycle pulse, coincident with writeEnable

## Operation
- FSM states: IDLE, READ, EXEC, WRITE.
- IDLE:
  - instrReady = 1.
  - On instrValid && instrReady, latch opcode, dstAddr, srcAddrA, srcAddrB and imm, then go to READ.
- READ:
  - readAddrA/readAddrB are driven from the latched srcAddrA/srcAddrB.
  - readDataA/readDataB are latched into operand registers at the edge, then go to EXEC.
- EXEC:
  - Compute result, carryFlag and zeroFlag; register them, then go to WRITE.
- WRITE:
  - writeEnable = 1, writeAddr = latched dstAddr, writeData = result register.
  - done = 1.
  - Go to IDLE.
- instrReady = 0 in READ, EXEC and WRITE; instrValid is ignored in those states.
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A-B.
  - 010 AND: A&B.
  - 011 OR: A|B.
  - 100 XOR: A^B.
  - 101 ADDI: A+imm.
  - 110 LI: imm; operands unused.
  - 111 SLT: 16'h0001 if A<B signed (two's complement), else 16'h0000.
- Arithmetic and width rules:
  - ADD/ADDI compute 17 bits; result = low 16, carryFlag = bit 16.
  - SUB: carryFlag = 1 when A<B unsigned (borrow).
  - AND/OR/XOR/LI/SLT: carryFlag = 0.
  - zeroFlag = (result == 0) for every opcode.
  - Flags change only at the EXEC edge and hold otherwise.
- Register address 0 is an ordinary register; writes to it are performed.
- Same-register operands (srcAddrA == srcAddrB == dstAddr) are legal. Operands are the pre-write values.
- readAddrA/readAddrB hold the last latched source addresses outside READ. They are 0 after reset.
- writeAddr/writeData hold their last values outside WRITE. writeEnable qualifies them.

## Timing
- Reset values:
  - state IDLE; instrReady 0 while rst = 1, 1 in the first cycle after rst deasserts.
  - writeEnable 0, done 0, carryFlag 0, zeroFlag 0.
  - readAddrA/B, writeAddr, writeData all 0.
- writeEnable = (state == WRITE) && !rst, combinational.
  - rst asserted during WRITE suppresses that write.
  - rst asserted in READ or EXEC aborts the instruction; no write ever occurs.
- Latency:
  - Instruction accepted at edge 0; READ in cycle 1, EXEC in cycle 2, WRITE in cycle 3.
  - Register file updated at edge 4.
  - instrReady returns high in cycle 4.
- Throughput: one instruction per 4 cycles with instrValid held high.
- No forwarding is needed. A dependent instruction accepted at edge 4 reads in cycle 5, after the write has landed.

## Test plan
- **Reset:** hold rst 2 cycles.
  - During reset: instrReady = 0, writeEnable = 0, flags = 0.
  - Cycle after release: instrReady = 1.
- **Load and add:**
  - LI r1 = 0x1234, LI r2 = 0x00FF.
  - ADD r3 = r1 + r2 -> writeData 0x1333 to addr 3 in the cycle 3 after acceptance; carry 0, zero 0.
- **Borrow:** SUB r4 = r2 - r1 -> 0xEECB, carry 1.
- **Carry and zero:**
  - LI r5 = 0xFFFF, ADDI r6 = r5 + 0x0001 -> 0x0000, carry 1, zero 1.
- **Signed compare and aliasing:**
  - LI r7 = 0x8000, LI r8 = 0x0001, SLT r9 = r7 < r8 -> 0x0001.
  - ADD r7 = r7 + r7 -> 0x0000, carry 1.
- **Handshake and reset mid-op:**
  - instrValid held high for 12 cycles -> exactly 3 acceptances, 3 done pulses, 4 cycles apart.
  - rst pulsed in EXEC of an ADD to r10 -> no writeEnable; r10 stays 0; instrReady = 1 the cycle after release.

Source files
------------

// File: rtl/alu_sequencer.sv
// Four-state instruction sequencer that masters a 32 x 16 register file:
// latch instruction, read operands, execute, write back.
module alu_sequencer #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instrValid,
   output logic              instrReady,
   input  logic [2:0]        opcode,
   input  logic [ADDR_W-1:0] dstAddr,
   input  logic [ADDR_W-1:0] srcAddrA,
   input  logic [ADDR_W-1:0] srcAddrB,
   input  logic [DATA_W-1:0] imm,
   output logic [ADDR_W-1:0] readAddrA,
   output logic [ADDR_W-1:0] readAddrB,
   input  logic [DATA_W-1:0] readDataA,
   input  logic [DATA_W-1:0] readDataB,
   output logic              writeEnable,
   output logic [ADDR_W-1:0] writeAddr,
   output logic [DATA_W-1:0] writeData,
   output logic              carryFlag,
   output logic              zeroFlag,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_ADDI = 3'b101;
   localparam logic [2:0] OP_LI   = 3'b110;
   localparam logic [2:0] OP_SLT  = 3'b111;

   state_t              state_q, state_d;
   logic [2:0]          opcode_q, opcode_d;
   logic [ADDR_W-1:0]   dst_q, dst_d;
   logic [ADDR_W-1:0]   src_a_q, src_a_d;
   logic [ADDR_W-1:0]   src_b_q, src_b_d;
   logic [DATA_W-1:0]   imm_q, imm_d;
   logic [DATA_W-1:0]   op_a_q, op_a_d;
   logic [DATA_W-1:0]   op_b_q, op_b_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                carry_q, carry_d;
   logic                zero_q, zero_d;

   logic [DATA_W:0]     sum;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_carry;

   always_comb begin
      sum       = '0;
      alu_res   = '0;
      alu_carry = 1'b0;
      case (opcode_q)
         OP_ADD: begin
            sum       = {1'b0, op_a_q} + {1'b0, op_b_q};
            alu_res   = sum[DATA_W-1:0];
            alu_carry = sum[DATA_W];
         end
         OP_SUB: begin
            alu_res   = op_a_q - op_b_q;
            alu_carry = (op_a_q < op_b_q);
         end
         OP_AND:  alu_res = op_a_q & op_b_q;
         OP_OR:   alu_res = op_a_q | op_b_q;
         OP_XOR:  alu_res = op_a_q ^ op_b_q;
         OP_ADDI: begin
            sum       = {1'b0, op_a_q} + {1'b0, imm_q};
            alu_res   = sum[DATA_W-1:0];
            alu_carry = sum[DATA_W];
         end
         OP_LI:   alu_res = imm_q;
         OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a_q) < $signed(op_b_q))};
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      opcode_d  = opcode_q;
      dst_d     = dst_q;
      src_a_d   = src_a_q;
      src_b_d   = src_b_q;
      imm_d     = imm_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      wr_addr_d = wr_addr_q;
      result_d  = result_q;
      carry_d   = carry_q;
      zero_d    = zero_q;
      case (state_q)
         IDLE: if (instrValid) begin
            opcode_d = opcode;
            dst_d    = dstAddr;
            src_a_d  = srcAddrA;
            src_b_d  = srcAddrB;
            imm_d    = imm;
            state_d  = READ;
         end
         READ: begin
            op_a_d  = readDataA;
            op_b_d  = readDataB;
            state_d = EXEC;
         end
         EXEC: begin
            // Write port address/data are held separately so they stay stable
            // after a new instruction overwrites dst_q.
            result_d  = alu_res;
            carry_d   = alu_carry;
            zero_d    = (alu_res == '0);
            wr_addr_d = dst_q;
            state_d   = WRITE;
         end
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         opcode_q  <= '0;
         dst_q     <= '0;
         src_a_q   <= '0;
         src_b_q   <= '0;
         imm_q     <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         wr_addr_q <= '0;
         result_q  <= '0;
         carry_q   <= 1'b0;
         zero_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         dst_q     <= dst_d;
         src_a_q   <= src_a_d;
         src_b_q   <= src_b_d;
         imm_q     <= imm_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         wr_addr_q <= wr_addr_d;
         result_q  <= result_d;
         carry_q   <= carry_d;
         zero_q    <= zero_d;
      end
   end

   // Gated by rst so a reset landing in WRITE kills the write immediately.
   assign instrReady  = (state_q == IDLE)  && !rst;
   assign writeEnable = (state_q == WRITE) && !rst;
   assign done        = writeEnable;
   assign readAddrA   = src_a_q;
   assign readAddrB   = src_b_q;
   assign writeAddr   = wr_addr_q;
   assign writeData   = result_q;
   assign carryFlag   = carry_q;
   assign zeroFlag    = zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural register file attached.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        instrValid;
   logic        instrReady;
   logic [2:0]  opcode;
   logic [4:0]  dstAddr, srcAddrA, srcAddrB;
   logic [15:0] imm;
   logic [4:0]  readAddrA, readAddrB;
   logic [15:0] readDataA, readDataB;
   logic        writeEnable;
   logic [4:0]  writeAddr;
   logic [15:0] writeData;
   logic        carryFlag, zeroFlag, done;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] rf [32] = '{default: 16'h0000};

   always #5 clk = ~clk;

   alu_sequencer #(.DATA_W(16), .ADDR_W(5)) dut (
      .clk(clk), .rst(rst),
      .instrValid(instrValid), .instrReady(instrReady),
      .opcode(opcode), .dstAddr(dstAddr), .srcAddrA(srcAddrA), .srcAddrB(srcAddrB), .imm(imm),
      .readAddrA(readAddrA), .readAddrB(readAddrB),
      .readDataA(readDataA), .readDataB(readDataB),
      .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
      .carryFlag(carryFlag), .zeroFlag(zeroFlag), .done(done)
   );

   assign readDataA = rf[readAddrA];
   assign readDataB = rf[readAddrB];
   always @(posedge clk) if (writeEnable) rf[writeAddr] <= writeData;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [4:0] d, a, b, input logic [15:0] im);
      @(negedge clk);
      chk("ready_before_issue", instrReady, 1'b1);
      instrValid = 1'b1; opcode = op; dstAddr = d; srcAddrA = a; srcAddrB = b; imm = im;
      @(posedge clk);
      #1 instrValid = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [4:0] d, a, b,
                         input logic [15:0] im, input logic [15:0] exp_data,
                         input logic exp_c, input logic exp_z);
      issue(op, d, a, b, im);
      @(negedge clk);   // READ
      chk({tag, "_raddrA"}, readAddrA, a);
      chk({tag, "_raddrB"}, readAddrB, b);
      chk({tag, "_we_read"}, writeEnable, 1'b0);
      @(negedge clk);   // EXEC
      chk({tag, "_we_exec"}, writeEnable, 1'b0);
      @(negedge clk);   // WRITE
      chk({tag, "_we"}, writeEnable, 1'b1);
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_ready_wr"}, instrReady, 1'b0);
      chk({tag, "_waddr"}, writeAddr, d);
      chk({tag, "_wdata"}, writeData, exp_data);
      chk({tag, "_carry"}, carryFlag, exp_c);
      chk({tag, "_zero"}, zeroFlag, exp_z);
   endtask

   initial begin
      int acc, dn, first_dn, last_dn;
      rst = 1'b1; instrValid = 1'b0; opcode = '0; dstAddr = '0;
      srcAddrA = '0; srcAddrB = '0; imm = '0;

      // Reset
      @(negedge clk);
      chk("rst_ready", instrReady, 1'b0);
      chk("rst_we", writeEnable, 1'b0);
      chk("rst_carry", carryFlag, 1'b0);
      chk("rst_zero", zeroFlag, 1'b0);
      chk("rst_raddrA", readAddrA, 5'd0);
      chk("rst_wdata", writeData, 16'h0);
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rel_ready", instrReady, 1'b1);

      // Load and add, borrow, carry/zero, signed compare, aliasing
      run_op("li_r1",  3'b110, 5'd1, 5'd0, 5'd0, 16'h1234, 16'h1234, 1'b0, 1'b0);
      run_op("li_r2",  3'b110, 5'd2, 5'd0, 5'd0, 16'h00FF, 16'h00FF, 1'b0, 1'b0);
      run_op("add_r3", 3'b000, 5'd3, 5'd1, 5'd2, 16'h0000, 16'h1333, 1'b0, 1'b0);
      run_op("sub_r4", 3'b001, 5'd4, 5'd2, 5'd1, 16'h0000, 16'hEECB, 1'b1, 1'b0);
      run_op("and_r13", 3'b010, 5'd13, 5'd1, 5'd2, 16'h0000, 16'h0034, 1'b0, 1'b0);
      run_op("or_r14",  3'b011, 5'd14, 5'd1, 5'd2, 16'h0000, 16'h12FF, 1'b0, 1'b0);
      run_op("xor_r15", 3'b100, 5'd15, 5'd1, 5'd2, 16'h0000, 16'h12CB, 1'b0, 1'b0);
      run_op("li_r5",  3'b110, 5'd5, 5'd0, 5'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
      run_op("addi_r6", 3'b101, 5'd6, 5'd5, 5'd0, 16'h0001, 16'h0000, 1'b1, 1'b1);
      run_op("li_r7",  3'b110, 5'd7, 5'd0, 5'd0, 16'h8000, 16'h8000, 1'b0, 1'b0);
      run_op("li_r8",  3'b110, 5'd8, 5'd0, 5'd0, 16'h0001, 16'h0001, 1'b0, 1'b0);
      run_op("slt_r9", 3'b111, 5'd9, 5'd7, 5'd8, 16'h0000, 16'h0001, 1'b0, 1'b0);
      run_op("slt_r16", 3'b111, 5'd16, 5'd8, 5'd7, 16'h0000, 16'h0000, 1'b0, 1'b1);
      run_op("add_r7", 3'b000, 5'd7, 5'd7, 5'd7, 16'h0000, 16'h0000, 1'b1, 1'b1);
      run_op("li_r0",  3'b110, 5'd0, 5'd0, 5'd0, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0);
      @(negedge clk);
      chk("rf3", rf[3], 16'h1333);
      chk("rf4", rf[4], 16'hEECB);
      chk("rf7", rf[7], 16'h0000);
      chk("rf0", rf[0], 16'h5A5A);

      // instrValid held 12 cycles: accept at cycles 0,4,8; done at 3,7,11
      acc = 0; dn = 0; first_dn = -1; last_dn = -1;
      instrValid = 1'b1; opcode = 3'b110; dstAddr = 5'd11; imm = 16'h0000;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) @(negedge clk);
         if (instrReady) acc++;
         if (done) begin
            dn++;
            if (first_dn < 0) first_dn = i;
            last_dn = i;
         end
         @(posedge clk);
      end
      #1 instrValid = 1'b0;
      chk("hs_accepts", acc, 3);
      chk("hs_dones", dn, 3);
      chk("hs_first_done", first_dn, 3);
      chk("hs_done_span", last_dn - first_dn, 8);
      chk("hs_zero", zeroFlag, 1'b1);

      // Reset during EXEC aborts the ADD to r10
      issue(3'b000, 5'd10, 5'd1, 5'd2, 16'h0000);
      @(negedge clk);   // READ
      @(negedge clk);   // EXEC
      rst = 1'b1;
      #1;
      chk("abort_we", writeEnable, 1'b0);
      chk("abort_ready_rst", instrReady, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_ready", instrReady, 1'b1);
      chk("abort_we_after", writeEnable, 1'b0);
      chk("abort_zero_clr", zeroFlag, 1'b0);
      repeat (4) @(negedge clk);
      chk("abort_rf10", rf[10], 16'h0000);

      // Reset landing in WRITE suppresses that write
      issue(3'b000, 5'd12, 5'd1, 5'd2, 16'h0000);
      @(negedge clk); @(negedge clk); @(negedge clk);   // WRITE
      chk("wrrst_we_pre", writeEnable, 1'b1);
      rst = 1'b1;
      #1;
      chk("wrrst_we", writeEnable, 1'b0);
      chk("wrrst_done", done, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("wrrst_rf12", rf[12], 16'h0000);
      chk("wrrst_ready", instrReady, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
